// File: rtl/aqp_esp_cmd_pkg.sv
// Command codes and payload byte-lane offsets for ESP messages.
// Shared by the ESP SPI command block and the message handler.
package aqp_esp_cmd_pkg;

  localparam logic [7:0] CMD_RESET           = 8'h01;
  localparam logic [7:0] CMD_SET_KEYB_MATRIX = 8'h10;
  localparam logic [7:0] CMD_SET_HCTRL       = 8'h11;
  localparam logic [7:0] CMD_WRITE_KBBUF     = 8'h12;

  // Newest payload byte sits in the top lane; earlier bytes shift down by 8.
  localparam int LANE_HCTRL1 = 48;
  localparam int LANE_HCTRL2 = 56;
  localparam int LANE_KBBUF  = 56;

endpackage

// File: rtl/aqp_kbbuf_fifo.sv
// Synchronous keyboard FIFO with registered head data (0 when empty).
// Pointers carry one extra wrap bit; clear has priority over push and pop.
module aqp_kbbuf_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             dropped_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic             doPush, doPop;

  assign empty_o   = (wrPtr_q == rdPtr_q);
  assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdData_o  = rdData_q;
  assign dropped_o = push_i && full_o && !pop_i && !clear_i;

  // A push into a full FIFO is only accepted when a pop frees the head slot.
  always_comb begin
    doPush   = push_i && (!full_o || pop_i);
    doPop    = pop_i && !empty_o;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    rdData_d = '0;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
      if (wrPtr_d != rdPtr_d) begin
        if (doPush && (rdPtr_d[AW-1:0] == wrPtr_q[AW-1:0])) rdData_d = data_i;
        else rdData_d = mem_q[rdPtr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      rdData_q <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      rdData_q <= rdData_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush && !clear_i) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/aqp_esp_msg_handler.sv
// Executes non-bus ESP commands: reset request, keyboard matrix, hand controllers, key buffer.
// Define AQP_KBBUF_OVF_EN to build the sticky key-buffer overflow flag.
module aqp_esp_msg_handler
  import aqp_esp_cmd_pkg::*;
#(
  parameter int KBBUF_DEPTH  = 16,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        spi_msg_end_i,
  input  logic [7:0]  spi_cmd_i,
  input  logic [63:0] spi_rxdata_i,
  output logic [63:0] keyb_matrix_o,
  output logic [7:0]  hctrl1_o,
  output logic [7:0]  hctrl2_o,
  output logic        reset_req_o,
  output logic [7:0]  kbbuf_rddata_o,
  input  logic        kbbuf_rd_i,
  input  logic        kbbuf_clear_i,
  output logic        kbbuf_empty_o,
  output logic        kbbuf_ovf_o
);

  localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES);

  logic [63:0] keybMatrix_q, keybMatrix_d;
  logic [7:0]  hctrl1_q, hctrl1_d;
  logic [7:0]  hctrl2_q, hctrl2_d;
  logic [7:0]  resetCnt_q, resetCnt_d;
  logic        kbPush;
  logic        kbFull;

  // Commands act only on the end-of-message strobe; a new RESET reloads the counter.
  always_comb begin
    keybMatrix_d = keybMatrix_q;
    hctrl1_d     = hctrl1_q;
    hctrl2_d     = hctrl2_q;
    resetCnt_d   = (resetCnt_q != 8'd0) ? resetCnt_q - 8'd1 : 8'd0;
    kbPush       = 1'b0;
    if (spi_msg_end_i) begin
      case (spi_cmd_i)
        CMD_RESET:           resetCnt_d   = RESET_LOAD;
        CMD_SET_KEYB_MATRIX: keybMatrix_d = spi_rxdata_i;
        CMD_SET_HCTRL: begin
          hctrl1_d = spi_rxdata_i[LANE_HCTRL1 +: 8];
          hctrl2_d = spi_rxdata_i[LANE_HCTRL2 +: 8];
        end
        CMD_WRITE_KBBUF:     kbPush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      keybMatrix_q <= '1;
      hctrl1_q     <= 8'hFF;
      hctrl2_q     <= 8'hFF;
      resetCnt_q   <= 8'd0;
    end else begin
      keybMatrix_q <= keybMatrix_d;
      hctrl1_q     <= hctrl1_d;
      hctrl2_q     <= hctrl2_d;
      resetCnt_q   <= resetCnt_d;
    end
  end

  assign keyb_matrix_o = keybMatrix_q;
  assign hctrl1_o      = hctrl1_q;
  assign hctrl2_o      = hctrl2_q;
  assign reset_req_o   = (resetCnt_q != 8'd0);

`ifdef AQP_KBBUF_OVF_EN
  logic kbDropped;
  logic ovf_q, ovf_d;
`endif

  aqp_kbbuf_fifo #(
    .DEPTH (KBBUF_DEPTH),
    .WIDTH (8)
  ) u_kbbuf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (kbPush),
    .data_i    (spi_rxdata_i[LANE_KBBUF +: 8]),
    .pop_i     (kbbuf_rd_i),
    .clear_i   (kbbuf_clear_i),
    .rdData_o  (kbbuf_rddata_o),
    .empty_o   (kbbuf_empty_o),
    .full_o    (kbFull),
`ifdef AQP_KBBUF_OVF_EN
    .dropped_o (kbDropped)
`else
    .dropped_o ()
`endif
  );

`ifdef AQP_KBBUF_OVF_EN
  always_comb begin
    ovf_d = ovf_q;
    if (kbbuf_clear_i) ovf_d = 1'b0;
    else if (kbDropped) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign kbbuf_ovf_o = ovf_q;
`else
  assign kbbuf_ovf_o = 1'b0;
`endif

  // Full is only needed inside the FIFO today; kept visible for an I/O status bit.
  logic unusedFull;
  assign unusedFull = kbFull;

endmodule
